// File: rtl/prbs_pkg.sv
// Shared definitions for the XNOR PRBS7 checker and generator.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int PRBS_LEN   = 7;
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;
    localparam int WIN_LEN    = 64;

endpackage

// File: rtl/prbs_xnor_next.sv
// Next-bit function of the x^7 + x^6 + 1 XNOR LFSR; shared with the generator.
module prbs_xnor_next
    import prbs_pkg::*;
(
    input  logic [PRBS_LEN-1:0] sr,
    output logic                exp_bit
);

    assign exp_bit = ~(sr[PRBS_TAP_A] ^ sr[PRBS_TAP_B]);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS7 (XNOR) bit-error checker.
// Optional macro PRBS_CHECKER_BITCNT_EN adds the 32-bit bit_count output.
//
// state  | meaning
// SEED   | load 7 received bits into sr; all-ones seed restarts
// VERIFY | predict bits from sr, need LOCK_CNT matches in a row
// LOCKED | free-running prediction, count errors, drop on window threshold
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int ERR_THRESH = 8,
    parameter int ERRCNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_bit,
    input  logic                clr,
    output logic                locked,
    output logic                err_pulse,
`ifdef PRBS_CHECKER_BITCNT_EN
    output logic [31:0]         bit_count,
`endif
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int SEED_W  = $clog2(PRBS_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WERR_W  = $clog2(ERR_THRESH + 1);
    localparam int WIN_W   = $clog2(WIN_LEN);

    state_t              state_q;
    state_t              state_d;
    logic [PRBS_LEN-1:0] sr;
    logic                exp_bit;
    logic [SEED_W-1:0]   seed_cnt;
    logic [MATCH_W-1:0]  match_cnt;
    logic [WIN_W-1:0]    win_cnt;
    logic [WERR_W-1:0]   werr;

    logic mismatch;
    logic seed_last;
    logic seed_lockup;
    logic lock_hit;
    logic thresh_hit;
    logic win_last;
    logic err_hit;

    prbs_xnor_next u_next (
        .sr      (sr),
        .exp_bit (exp_bit)
    );

    assign mismatch    = in_bit ^ exp_bit;
    assign seed_last   = (seed_cnt == SEED_W'(PRBS_LEN - 1));
    // The XNOR LFSR never leaves the all-ones state, so such a seed is useless.
    assign seed_lockup = &{sr[PRBS_LEN-2:0], in_bit};
    assign lock_hit    = (match_cnt == MATCH_W'(LOCK_CNT - 1));
    assign thresh_hit  = (werr == WERR_W'(ERR_THRESH - 1));
    assign win_last    = (win_cnt == WIN_W'(WIN_LEN - 1));
    assign err_hit     = in_valid && (state_q == LOCKED) && mismatch;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SEED;
        else     state_q <= state_d;
    end

    // Next-state decode; only valid bits move the FSM.
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                SEED:    if (seed_last && !seed_lockup) state_d = VERIFY;
                VERIFY:  if (mismatch)                  state_d = SEED;
                         else if (lock_hit)             state_d = LOCKED;
                LOCKED:  if (mismatch && thresh_hit)    state_d = SEED;
                default:                                state_d = SEED;
            endcase
        end
    end

    // Shift register, sync counters, window tracking and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            werr      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            locked    <= (state_d == LOCKED);
            err_pulse <= err_hit;
            if (in_valid) begin
                case (state_q)
                    SEED: begin
                        sr        <= {sr[PRBS_LEN-2:0], in_bit};
                        seed_cnt  <= seed_last ? '0 : seed_cnt + SEED_W'(1);
                        match_cnt <= '0;
                    end
                    VERIFY: begin
                        sr        <= {sr[PRBS_LEN-2:0], exp_bit};
                        match_cnt <= mismatch ? '0 : match_cnt + MATCH_W'(1);
                        seed_cnt  <= '0;
                        win_cnt   <= '0;
                        werr      <= '0;
                    end
                    LOCKED: begin
                        // Received bits never enter sr here, so one bad bit stays one error.
                        sr      <= {sr[PRBS_LEN-2:0], exp_bit};
                        win_cnt <= win_cnt + WIN_W'(1);
                        if (mismatch && thresh_hit) werr <= '0;
                        else if (win_last)          werr <= '0;
                        else                        werr <= werr + WERR_W'(mismatch);
                    end
                    default: sr <= sr;
                endcase
            end
        end
    end

    // Saturating error counter; clear beats a coincident error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            err_count <= '0;
        else if (clr)                       err_count <= '0;
        else if (err_hit && ~&err_count)    err_count <= err_count + ERRCNT_W'(1);
    end

`ifdef PRBS_CHECKER_BITCNT_EN
    // Saturating count of valid bits checked while locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        bit_count <= '0;
        else if (clr)   bit_count <= '0;
        else if (in_valid && (state_q == LOCKED) && ~&bit_count)
                        bit_count <= bit_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised self-checking bench for prbs_checker with a behavioural model.
module tb_prbs_checker;

    localparam int LOCK_CNT   = 16;
    localparam int ERR_THRESH = 8;
    localparam int ERRCNT_W   = 16;
    localparam longint CNT_MAX = (longint'(1) << ERRCNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic clr = 1'b0;
    logic locked;
    logic err_pulse;
    logic [ERRCNT_W-1:0] err_count;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [31:0] bit_count;
`endif

    prbs_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .ERR_THRESH (ERR_THRESH),
        .ERRCNT_W   (ERRCNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
`ifdef PRBS_CHECKER_BITCNT_EN
        .bit_count (bit_count),
`endif
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 acquiring seed, 1 confirming, 2 locked
    int         m_mode = 0;
    logic [6:0] m_hist = '0;
    int         m_nseed = 0;
    int         m_nmatch = 0;
    longint     m_nlk = 0;
    int         m_werr = 0;
    logic       m_pulse = 1'b0;
    longint     m_cnt = 0;
    longint     m_bits = 0;
    logic       m_e;

    function automatic logic prbs_pred(input logic [6:0] h);
        return ~(h[6] ^ h[5]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_hist = '0; m_nseed = 0; m_nmatch = 0;
            m_nlk = 0; m_werr = 0; m_pulse = 1'b0; m_cnt = 0; m_bits = 0;
        end else begin
            m_pulse = 1'b0;
            if (in_valid) begin
                if (m_mode == 0) begin
                    m_hist = {m_hist[5:0], in_bit};
                    m_nseed++;
                    if (m_nseed == 7) begin
                        m_nseed = 0;
                        if (m_hist != 7'h7f) begin m_mode = 1; m_nmatch = 0; end
                    end
                end else if (m_mode == 1) begin
                    m_e = prbs_pred(m_hist);
                    m_hist = {m_hist[5:0], m_e};
                    if (in_bit == m_e) begin
                        m_nmatch++;
                        if (m_nmatch == LOCK_CNT) begin m_mode = 2; m_nlk = 0; m_werr = 0; end
                    end else begin
                        m_mode = 0; m_nseed = 0;
                    end
                end else begin
                    m_e = prbs_pred(m_hist);
                    m_hist = {m_hist[5:0], m_e};
                    if (m_nlk % 64 == 0) m_werr = 0;
                    m_nlk++;
                    if (m_bits < 64'hFFFF_FFFF) m_bits++;
                    if (in_bit != m_e) begin
                        m_pulse = 1'b1;
                        if (m_cnt < CNT_MAX) m_cnt++;
                        m_werr++;
                        if (m_werr == ERR_THRESH) begin m_mode = 0; m_nseed = 0; end
                    end
                end
            end
            if (clr) begin m_cnt = 0; m_bits = 0; end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the active edge.
    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("locked", locked, (m_mode == 2));
            chk("err_pulse", err_pulse, m_pulse);
            chk("err_count", err_count, m_cnt);
`ifdef PRBS_CHECKER_BITCNT_EN
            chk("bit_count", bit_count, m_bits);
`endif
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] g = '0;

    task automatic gnext(output logic b);
        b = ~(g[6] ^ g[5]);
        g = {g[5:0], b};
    endtask

    task automatic cyc(input logic v, input logic b, input logic c);
        in_valid = v; in_bit = b; clr = c;
        @(posedge clk); #2;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic b;
        int   seen;
        int   rate;
        logic v;
        logic any_lock;

        repeat (2) @(posedge clk);
        #2;
        cmp_en = 1'b1;

        // reset held while random valid data arrives
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'($urandom), 1'($urandom));
            chk("rst_locked", locked, 0);
            chk("rst_pulse", err_pulse, 0);
            chk("rst_count", err_count, 0);
        end
        rst = 1'b0;

        // clean stream from seed 0
        g = '0; seen = 0;
        for (int n = 1; n <= 1000; n++) begin
            gnext(b); cyc(1'b1, b, 1'b0);
            if (seen == 0 && locked) seen = n;
        end
        chk("lock_bit", seen, 23);
        chk("clean_count", err_count, 0);
        chk("clean_locked", locked, 1);

        // single error
        for (int n = 1; n < 100; n++) begin gnext(b); cyc(1'b1, b, 1'b0); end
        gnext(b); cyc(1'b1, ~b, 1'b0);
        chk("single_pulse", err_pulse, 1);
        chk("single_count", err_count, 1);
        gnext(b); cyc(1'b1, b, 1'b0);
        chk("single_pulse_off", err_pulse, 0);
        chk("single_locked", locked, 1);
        chk("single_count_hold", err_count, 1);

        // burst of 8 errors in one fresh window
        gnext(b); cyc(1'b1, b, 1'b1);
        chk("clr_count", err_count, 0);
        for (int k = 0; k < 64 && (m_nlk % 64) != 0; k++) begin gnext(b); cyc(1'b1, b, 1'b0); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin gnext(b); cyc(1'b1, b, 1'b0); end
            gnext(b); cyc(1'b1, ~b, 1'b0);
            chk("burst_locked", locked, (i < 7));
        end
        chk("burst_count", err_count, 8);
        for (int n = 1; n <= 23; n++) begin
            gnext(b); cyc(1'b1, b, 1'b0);
            if (n == 22) chk("relock_early", locked, 0);
        end
        chk("relock", locked, 1);
        chk("relock_count", err_count, 8);

        // stuck-at-one line
        rst_pulse();
        any_lock = 1'b0;
        for (int n = 0; n < 200; n++) begin
            cyc(1'b1, 1'b1, 1'b0);
            any_lock |= locked;
        end
        chk("stuck_locked", any_lock, 0);

        // valid gaps, then clear coincident with an error
        rst_pulse();
        g = '0; seen = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c % 2 == 1) cyc(1'b0, 1'($urandom), 1'b0);
            else begin gnext(b); cyc(1'b1, b, 1'b0); end
            if (seen == 0 && locked) seen = c;
        end
        chk("gap_lock_cycle", seen, 46);
        gnext(b); cyc(1'b1, ~b, 1'b0);
        chk("gap_err_count", err_count, 1);
        gnext(b); cyc(1'b1, ~b, 1'b1);
        chk("clr_err_pulse", err_pulse, 1);
        chk("clr_err_count", err_count, 0);
        chk("clr_locked", locked, 1);

        // randomised traffic at several error rates (per mille)
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0: rate = 0;
                1: rate = 5;
                2: rate = 50;
                default: rate = 250;
            endcase
            for (int i = 0; i < 400; i++) begin
                v = ($urandom_range(0, 3) != 0);
                b = 1'($urandom);
                if (v) begin
                    gnext(b);
                    if ($urandom_range(0, 999) < rate) b = ~b;
                end
                if ($urandom_range(0, 999) == 0) rst_pulse();
                cyc(v, b, ($urandom_range(0, 99) == 0));
            end
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS7 checker. It receives a bitstream produced by an XNOR-feedback LFSR (polynomial x^7 + x^6 + 1, next bit = ~(s[6] ^ s[5])), self-synchronises to it and counts bit errors. It sits at the receive end of the serial link-test path and pairs with the XNOR PRBS generator.

## Interface
Parameters:
- `LOCK_CNT`, default 16: consecutive matching bits required in VERIFY before declaring lock.
- `ERR_THRESH`, default 8: errors within one 64-bit window that force loss of lock.
- `ERRCNT_W`, default 16: width of `err_count`.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- `clk` input, 1: system clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `in_valid` input, 1: `in_bit` is valid this cycle.
- `in_bit` input, 1: received serial bit.
- `clr` input, 1: synchronous clear of the counters; lock state is unaffected.
- `locked` output, 1: checker is synchronised.
- `err_pulse` output, 1: one-cycle strobe per detected error.
- `err_count` output, ERRCNT_W: saturating count of errors seen while LOCKED.

## Operation
- Internal state: 7-bit shift register `sr`; expected bit `exp = ~(sr[6] ^ sr[5])`; shift direction is `sr <= {sr[5:0], b}`.
- Only cycles with `in_valid`=1 advance anything. Idle cycles hold all state.
- States:
  - SEED: shift `in_bit` into `sr`; count 7 bits, then go to VERIFY.
    - If `sr` is all-ones after the 7th bit (XNOR lock-up value), restart SEED.
  - VERIFY: compare `in_bit` with `exp`; shift `exp` into `sr`.
    - Match: increment the match counter. Reaching `LOCK_CNT` goes to LOCKED.
    - Any mismatch: return to SEED (match counter cleared).
  - LOCKED: shift `exp`; the received bit is never shifted in, so errors do not multiply.
    - Mismatch: `err_pulse`=1, `err_count`+1 (saturating at all-ones), window error counter +1.
    - 64-bit window counter wraps every 64 valid bits, clearing the window error counter.
    - Window error count reaching `ERR_THRESH`: go to SEED and deassert `locked`. `err_count` is kept.
- `clr`: zeroes `err_count` (and `bit_count` when enabled). If `clr` and an error occur in the same cycle, `clr` wins and the count is 0; `err_pulse` still fires.
- Errors in SEED and VERIFY are not counted.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, state SEED, `sr`=0, all internal counters 0.
- All outputs are registered.
- `err_pulse` is high for exactly the one cycle after the clock edge that sampled the bad bit.
- `locked` rises on the edge that samples the `LOCK_CNT`-th matching bit. With a clean stream that is the 23rd valid bit (7 + 16).
- `locked` falls on the edge that samples the `ERR_THRESH`-th window error.
- `rst` mid-stream returns the block immediately to reset values. Reacquisition then starts from SEED.

## Configuration
- `PRBS_CHECKER_BITCNT_EN` defined:
  - Adds output `bit_count` (32-bit), a saturating count of valid bits checked in LOCKED.
  - It is cleared by `rst` and `clr`, and held when not LOCKED.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `prbs_pkg` holds:
  - state enum (SEED, VERIFY, LOCKED);
  - constants `PRBS_LEN`=7, `PRBS_TAP_A`=6, `PRBS_TAP_B`=5, `WIN_LEN`=64.
- Sub-module `prbs_xnor_next`: combinational function taking `sr` and returning `exp`. The same block is reused by the generator.
- Top: FSM, match counter, window counters, error/bit counters.

## Test plan
- Reset: assert `rst` with `in_valid`=1 and random bits -> `locked`=0, `err_pulse`=0, `err_count`=0 throughout.
- Clean stream: reference generator seeded 7'h00, continuous valid -> `locked`=1 after the 23rd bit; `err_count`=0 after 1000 bits.
- Single error: flip bit 100 of a locked stream -> `err_pulse` high exactly one cycle, `err_count`=1, `locked` stays 1.
- Burst: flip 8 bits within one 64-bit window -> `locked`=0 after the 8th error, `err_count`=8. Clean stream resumes -> `locked`=1 again 23 valid bits later.
- Stuck line: `in_bit`=1 for 200 valid bits -> `locked` never asserts (all-ones seed rejected).
- Valid gaps plus `clr`: `in_valid` toggling every cycle -> lock after 23 valid bits (46 cycles). Then `clr` coincident with an injected error -> `err_count`=0, `err_pulse`=1.
